// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg : shared types for the bit-serial subtractor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
// ---------------------------------------------------------------------------
// serial_subtractor_fs : 1-bit full subtractor (a - b - c)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_subtractor_fs (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic borrow_o,
  output logic diff_o
);

  assign diff_o   = a_i ^ b_i ^ c_i;
  assign borrow_o = (~a_i & b_i) | (~a_i & c_i) | (b_i & c_i);

endmodule : serial_subtractor_fs

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor : LSB-first bit-serial a - b - borrow, WIDTH cycles/op
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  import serial_sub_pkg::*;

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             fs_diff;
  logic             fs_borrow;

  serial_subtractor_fs u_fs (
    .a_i      (a_q[0]),
    .b_i      (b_q[0]),
    .c_i      (brw_q),
    .borrow_o (fs_borrow),
    .diff_o   (fs_diff)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ready_o = 1'b0;
    valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          brw_d   = borrow_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fs_diff, res_q[WIDTH-1:1]};
        brw_d = fs_borrow;
        // Visible outputs only change on the last bit so they hold between ops
        if (cnt_q == CNT_LAST) begin
          diff_d  = {fs_diff, res_q[WIDTH-1:1]};
          bout_d  = fs_borrow;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign diff_o   = diff_q;
  assign borrow_o = bout_q;

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor : directed self-checking bench, WIDTH = 8
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] diff;
  logic         bout;

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a),
    .b_i      (b),
    .borrow_i (bin),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .diff_o   (diff),
    .borrow_o (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, measure latency, check result, hand it off.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic [W-1:0] ed, input logic eb);
    int n;
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; a = ta; b = tb; bin = tbin;
    @(posedge clk); #1;
    valid_i = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(bout), 32'(eb));
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check({tag, "_handoff_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_handoff_diff"}, 32'(diff), 32'(ed));
  endtask

  logic [W-1:0] va [3];
  logic [W-1:0] vb [3];
  logic         vbin [3];
  logic [W-1:0] vd [3];

  initial begin
    int k, r, last;
    logic acc;
    tests = 0; fails = 0;
    valid_i = 1'b0; ready_i = 1'b0; a = '0; b = '0; bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(bout), 32'd0);

    // accepted on the first edge after reset release
    run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    run_op("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    run_op("v00_00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run_op("vFF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

    // busy-ignore and DONE hold: 0x10 - 0x01 = 0x0F
    valid_i = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("busy_ready", 32'(ready_o), 32'd0);
    valid_i = 1'b1; a = 8'hC3; b = 8'h77; bin = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("busy_valid", 32'(valid_o), 32'd1);
    check("busy_diff", 32'(diff), 32'h0F);
    check("busy_borrow", 32'(bout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_diff", 32'(diff), 32'h0F);
      check("hold_ready", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("hold_release", 32'(valid_o), 32'd0);

    // abort mid-operation, then a clean rerun
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid_i = 1'b1; a = 8'hA5; b = 8'h5A; bin = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valid_o) k++;
    end
    check("abort_no_valid", 32'(k), 32'd0);
    check("abort_diff_after", 32'(diff), 32'd0);
    run_op("vA5_5A", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0);

    // back-to-back with ready_i tied high
    va[0] = 8'h05; vb[0] = 8'h03; vbin[0] = 1'b0; vd[0] = 8'h02;
    va[1] = 8'h80; vb[1] = 8'h01; vbin[1] = 1'b1; vd[1] = 8'h7E;
    va[2] = 8'h01; vb[2] = 8'h02; vbin[2] = 1'b1; vd[2] = 8'hFE;
    ready_i = 1'b1;
    valid_i = 1'b1; a = va[0]; b = vb[0]; bin = vbin[0];
    k = 0; r = 0; last = 0;
    for (int c = 0; c < 60 && r < 3; c++) begin
      @(negedge clk);
      acc = ready_o && valid_i;
      if (valid_o) begin
        check("b2b_diff", 32'(diff), 32'(vd[r]));
        r++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (k > 0) check("b2b_interval", 32'(c - last), 32'd10);
        last = c;
        k++;
        if (k < 3) begin
          a = va[k]; b = vb[k]; bin = vbin[k];
        end else begin
          valid_i = 1'b0;
        end
      end
    end
    check("b2b_accepts", 32'(k), 32'd3);
    check("b2b_results", 32'(r), 32'd3);
    ready_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_subtractor

`default_nettype wire
